// File: rtl/ram_arbiter_v1.sv
// Two-master round-robin arbiter/sequencer for a single-port, synchronous-read RAM.
// Sub-word stores become a read cycle followed by a merged write cycle (RAM has no byte strobes).
module ram_arbiter_v1 #(
  parameter int addr_width = 10,
  parameter int data_width = 32,
  localparam int be_width = data_width / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [addr_width-1:0] m0_req_addr,
  input  logic [data_width-1:0] m0_req_wdata,
  input  logic [be_width-1:0]   m0_req_be,
  output logic                  m0_rsp_valid,
  output logic [data_width-1:0] m0_rsp_rdata,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [addr_width-1:0] m1_req_addr,
  input  logic [data_width-1:0] m1_req_wdata,
  input  logic [be_width-1:0]   m1_req_be,
  output logic                  m1_rsp_valid,
  output logic [data_width-1:0] m1_rsp_rdata,
  output logic                  ram_wr_en,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_in_data,
  input  logic [data_width-1:0] ram_out_data,
  output logic                  dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_owner_q, rsp_owner_d;
  logic                  rsp_read_q, rsp_read_d;
  logic                  rmw_owner_q, rmw_owner_d;
  logic [addr_width-1:0] rmw_addr_q, rmw_addr_d;
  logic [data_width-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [be_width-1:0]   rmw_be_q, rmw_be_d;

  logic                  sel;
  logic                  any_valid;
  logic                  sel_we;
  logic [addr_width-1:0] sel_addr;
  logic [data_width-1:0] sel_wdata;
  logic [be_width-1:0]   sel_be;

  // A request transfers on a rising edge where valid&ready are both high; ready
  // depends combinationally on valid, and fields must stay stable until then.
  always_comb begin
    any_valid = m0_req_valid | m1_req_valid;
    if (m0_req_valid && m1_req_valid) begin
      sel = ~last_grant_q;
    end else begin
      sel = m1_req_valid;
    end
    sel_we    = sel ? m1_req_we    : m0_req_we;
    sel_addr  = sel ? m1_req_addr  : m0_req_addr;
    sel_wdata = sel ? m1_req_wdata : m0_req_wdata;
    sel_be    = sel ? m1_req_be    : m0_req_be;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = 1'b0;
    rsp_owner_d  = rsp_owner_q;
    rsp_read_d   = 1'b0;
    rmw_owner_d  = rmw_owner_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_wdata_d  = rmw_wdata_q;
    rmw_be_d     = rmw_be_q;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    ram_wr_en    = 1'b0;
    ram_addr     = '0;
    ram_in_data  = '0;

    case (state_q)
      IDLE: begin
        // Gated by rst so nothing is accepted while reset is held.
        if (any_valid && !rst) begin
          m0_req_ready = ~sel;
          m1_req_ready = sel;
          last_grant_d = sel;
          ram_addr     = sel_addr;
          if (!sel_we) begin
            rsp_valid_d = 1'b1;
            rsp_owner_d = sel;
            rsp_read_d  = 1'b1;
          end else if (sel_be == {be_width{1'b1}}) begin
            ram_wr_en   = 1'b1;
            ram_in_data = sel_wdata;
            rsp_valid_d = 1'b1;
            rsp_owner_d = sel;
          end else if (sel_be != '0) begin
            rmw_owner_d = sel;
            rmw_addr_d  = sel_addr;
            rmw_wdata_d = sel_wdata;
            rmw_be_d    = sel_be;
            state_d     = RMW_WR;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_owner_d = sel;
          end
        end
      end
      RMW_WR: begin
        ram_wr_en = 1'b1;
        ram_addr  = rmw_addr_q;
        for (int i = 0; i < be_width; i++) begin
          ram_in_data[8*i +: 8] = rmw_be_q[i] ? rmw_wdata_q[8*i +: 8] : ram_out_data[8*i +: 8];
        end
        rsp_valid_d = 1'b1;
        rsp_owner_d = rmw_owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= 1'b0;
      rsp_read_q   <= 1'b0;
      rmw_owner_q  <= 1'b0;
      rmw_addr_q   <= '0;
      rmw_wdata_q  <= '0;
      rmw_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_read_q   <= rsp_read_d;
      rmw_owner_q  <= rmw_owner_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_wdata_q  <= rmw_wdata_d;
      rmw_be_q     <= rmw_be_d;
    end
  end

  // Read data is passed straight through from the RAM in the response cycle.
  assign m0_rsp_valid = rsp_valid_q & ~rsp_owner_q;
  assign m1_rsp_valid = rsp_valid_q & rsp_owner_q;
  assign m0_rsp_rdata = (m0_rsp_valid && rsp_read_q) ? ram_out_data : '0;
  assign m1_rsp_rdata = (m1_rsp_valid && rsp_read_q) ? ram_out_data : '0;
  assign dbg_state    = (state_q == RMW_WR);

endmodule
